acc_control_sequencer: RTL and testbench

- Fetch/decode/execute control FSM for the 16-bit accumulator machine.
- Owns the architectural registers AC, PC, MAR, MBR and IR.
- Drives the synchronous main memory: address, write data and write enable. Reads return one cycle after the address is presented.
- Drives the combinational ALU (alu_op, alu_a = AC, alu_b = MBR) and consumes alu_result. Sits between main memory and the ALU in the top-level computer.

---
 rtl/acc_control_sequencer_pkg.sv | 14 +
 rtl/acc_control_sequencer_instr_decode.sv | 26 ++
 rtl/acc_control_sequencer.sv | 101 ++++++++++
 tb/tb_acc_control_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/acc_control_sequencer_pkg.sv
// cpu_pkg: opcodes, ALU codes, FSM states and SKIPCOND conditions for the accumulator machine
package cpu_pkg;
  localparam logic [3:0] OP_HALT = 4'h0, OP_LOAD = 4'h1, OP_STORE = 4'h2, OP_ADD = 4'h3,
                         OP_SUBT = 4'h4, OP_AND = 4'h5, OP_OR = 4'h6, OP_XOR = 4'h7,
                         OP_SKIPCOND = 4'h8, OP_JUMP = 4'h9, OP_CLEAR = 4'hA, OP_SHL = 4'hB,
                         OP_SHR = 4'hC, OP_JUMPI = 4'hD, OP_NOPE = 4'hE, OP_NOPF = 4'hF;
  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b1000,
                         ALU_OR = 4'b1001, ALU_XOR = 4'b1010, ALU_SHL = 4'b0100,
                         ALU_SHR = 4'b0101;
  typedef enum logic [3:0] {
    S_FETCH0, S_FETCH1, S_FETCH2, S_DECODE, S_READ, S_EXEC, S_WB, S_STORE, S_STORE_WR, S_HALT
  } state_t;
  localparam logic [1:0] SC_NEG = 2'b00, SC_ZERO = 2'b01, SC_POS = 2'b10, SC_NEVER = 2'b11;
endpackage

// File: rtl/acc_control_sequencer_instr_decode.sv
// instr_decode: opcode -> instruction class flags and ALU operation code
module instr_decode
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       is_mem_read,
  output logic       is_store,
  output logic       is_alu,
  output logic       is_shift,
  output logic       is_reg_only,
  output logic [3:0] alu_code
);
  always_comb begin
    is_store    = opcode == OP_STORE;
    is_alu      = opcode inside {OP_ADD, OP_SUBT, OP_AND, OP_OR, OP_XOR};
    is_shift    = opcode inside {OP_SHL, OP_SHR};
    is_mem_read = is_alu || opcode inside {OP_LOAD, OP_JUMPI};
    is_reg_only = !is_mem_read && !is_store && opcode != OP_HALT;
    alu_code    = opcode == OP_SUBT ? ALU_SUB :
                  opcode == OP_AND  ? ALU_AND :
                  opcode == OP_OR   ? ALU_OR  :
                  opcode == OP_XOR  ? ALU_XOR :
                  opcode == OP_SHL  ? ALU_SHL :
                  opcode == OP_SHR  ? ALU_SHR : ALU_ADD;
  end
endmodule

// File: rtl/acc_control_sequencer.sv
// acc_control_sequencer: fetch/decode/execute FSM owning AC, PC, MAR, MBR and IR
module acc_control_sequencer
  import cpu_pkg::*;
#(
  parameter int          ADDR_W   = 14,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  output logic [3:0]  alu_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_result,
  output logic        halted,
  output logic [15:0] pc_out,
  output logic [15:0] ac_out,
  output logic [15:0] ir_out
);
  localparam logic [15:0] PC_MASK = 16'((32'd1 << ADDR_W) - 1);
  state_t      state;
  logic [15:0] ac, pc, mar, mbr, ir;
  logic [3:0]  op, alu_code;
  logic        is_mem_read, is_store, is_alu, is_shift, is_reg_only, skip;
  function automatic logic [15:0] pc_next(input logic [15:0] p);
    return (p + 16'd1) & PC_MASK;
  endfunction
  assign op = ir[15:12];
  instr_decode u_dec (
    .opcode(op), .is_mem_read(is_mem_read), .is_store(is_store), .is_alu(is_alu),
    .is_shift(is_shift), .is_reg_only(is_reg_only), .alu_code(alu_code)
  );
  always_comb begin
    skip = ir[11:10] == SC_NEG  ? ac[15] :
           ir[11:10] == SC_ZERO ? ac == 16'h0 :
           ir[11:10] == SC_POS  ? !ac[15] && ac != 16'h0 : 1'b0;
    alu_op = (state == S_WB && is_alu) || (state == S_DECODE && is_shift) ? alu_code : ALU_ADD;
  end
  assign mem_addr  = mar;
  assign mem_wdata = mbr;
  assign mem_we    = state == S_STORE_WR;
  assign halted    = state == S_HALT;
  assign alu_a     = ac;
  assign alu_b     = mbr;
  assign pc_out    = pc;
  assign ac_out    = ac;
  assign ir_out    = ir;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH0;
      pc    <= RESET_PC;
      ac    <= '0;
      mar   <= '0;
      mbr   <= '0;
      ir    <= '0;
    end else begin
      case (state)
        S_FETCH0: if (run) begin
          mar   <= pc;
          state <= S_FETCH1;
        end
        S_FETCH1: state <= S_FETCH2;
        S_FETCH2: begin
          ir    <= mem_rdata;
          pc    <= pc_next(pc);
          state <= S_DECODE;
        end
        S_DECODE: begin
          mar <= {4'h0, ir[11:0]};
          if (op == OP_CLEAR) ac <= '0;
          if (is_shift) ac <= alu_result;
          if (op == OP_JUMP) pc <= {4'h0, ir[11:0]};
          if (op == OP_SKIPCOND && skip) pc <= pc_next(pc);
          state <= is_reg_only ? S_FETCH0 : is_store ? S_STORE : is_mem_read ? S_READ : S_HALT;
        end
        S_READ: state <= S_EXEC;
        S_EXEC: begin
          mbr   <= mem_rdata;
          state <= S_WB;
        end
        S_WB: begin
          if (op == OP_LOAD) ac <= mbr;
          if (is_alu) ac <= alu_result;
          if (op == OP_JUMPI) pc <= mbr & PC_MASK;
          state <= S_FETCH0;
        end
        S_STORE: begin
          mbr   <= ac;
          state <= S_STORE_WR;
        end
        S_STORE_WR: state <= S_FETCH0;
        S_HALT: state <= S_HALT;
        default: state <= S_FETCH0;
      endcase
    end
  end
endmodule

// File: tb/tb_acc_control_sequencer.sv
// tb_acc_control_sequencer: directed program tests with a behavioural memory and ALU
module tb_acc_control_sequencer;
  logic        clk = 0, reset = 1, run = 0;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, alu_a, alu_b, alu_result, pc_out, ac_out, ir_out;
  logic [3:0]  alu_op;
  logic        mem_we, halted;
  logic [15:0] mem [0:16383];
  int          checks = 0, errors = 0;

  acc_control_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .halted(halted), .pc_out(pc_out), .ac_out(ac_out), .ir_out(ir_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[13:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[13:0]];
  end

  assign alu_result = alu_op == 4'b0000 ? alu_a + alu_b :
                      alu_op == 4'b0001 ? alu_a - alu_b :
                      alu_op == 4'b1000 ? alu_a & alu_b :
                      alu_op == 4'b1001 ? alu_a | alu_b :
                      alu_op == 4'b1010 ? alu_a ^ alu_b :
                      alu_op == 4'b0100 ? alu_a << 1 :
                      alu_op == 4'b0101 ? alu_a >> 1 : 16'h0;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic prog_reset;
    reset = 0;
    run = 0;
    for (int i = 0; i < 16384; i++) mem[i] = 16'h0;
  endtask

  task automatic release_reset(input logic r);
    @(negedge clk);
    run = r;
    reset = 1;
  endtask

  task automatic wait_halt(input int budget);
    int cyc = 0;
    while (!halted && cyc < budget) begin
      step(1);
      cyc++;
    end
    checks++;
    if (halted !== 1'b1) begin errors++; $display("FAIL halt_timeout got %b want 1 after %0d cycles", halted, cyc); end
  endtask

  task automatic test_reset;
    #2 reset = 0;
    #1;
    checks++; if (pc_out !== 16'h0) begin errors++; $display("FAIL rst_pc got %h want 0000", pc_out); end
    checks++; if (ac_out !== 16'h0) begin errors++; $display("FAIL rst_ac got %h want 0000", ac_out); end
    checks++; if (ir_out !== 16'h0) begin errors++; $display("FAIL rst_ir got %h want 0000", ir_out); end
    checks++; if (mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin errors++; $display("FAIL rst_mem got %h/%h want 0000/0000", mem_addr, mem_wdata); end
    checks++; if (mem_we !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL rst_flags got we=%b halt=%b want 0/0", mem_we, halted); end
    checks++; if (alu_op !== 4'h0) begin errors++; $display("FAIL rst_aluop got %h want 0", alu_op); end
  endtask

  task automatic test_program;
    prog_reset;
    mem[0] = 16'h1010; mem[1] = 16'h3011; mem[2] = 16'h2012; mem[3] = 16'h0000;
    mem['h10] = 16'h0005; mem['h11] = 16'h0003;
    release_reset(1);
    step(23);
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL prog_halt_early got %b want 0", halted); end
    step(1);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL prog_halt_24 got %b want 1", halted); end
    checks++; if (mem['h12] !== 16'h0008) begin errors++; $display("FAIL prog_m12 got %h want 0008", mem['h12]); end
    checks++; if (ac_out !== 16'h0008) begin errors++; $display("FAIL prog_ac got %h want 0008", ac_out); end
    checks++; if (pc_out !== 16'h0004) begin errors++; $display("FAIL prog_pc got %h want 0004", pc_out); end
    run = 0;
    step(5);
    checks++; if (halted !== 1'b1 || pc_out !== 16'h0004) begin errors++; $display("FAIL halt_absorb got %b/%h want 1/0004", halted, pc_out); end
  endtask

  task automatic test_skipcond;
    prog_reset;
    mem[0] = 16'hA000; mem[1] = 16'h8400; mem[2] = 16'h9030; mem[3] = 16'h0000; mem['h30] = 16'h0000;
    release_reset(1);
    wait_halt(60);
    checks++; if (pc_out !== 16'h0004) begin errors++; $display("FAIL skip_zero_pc got %h want 0004", pc_out); end
    prog_reset;
    mem[0] = 16'hA000; mem[1] = 16'h8800; mem[2] = 16'h9030; mem[3] = 16'h0000; mem['h30] = 16'h0000;
    release_reset(1);
    wait_halt(60);
    checks++; if (pc_out !== 16'h0031) begin errors++; $display("FAIL skip_pos_pc got %h want 0031", pc_out); end
  endtask

  task automatic test_negative;
    prog_reset;
    mem[0] = 16'h1010; mem[1] = 16'h3011; mem[2] = 16'h8000; mem[3] = 16'hA000; mem[4] = 16'h0000;
    mem['h10] = 16'h7FFF; mem['h11] = 16'h0001;
    release_reset(1);
    wait_halt(80);
    checks++; if (ac_out !== 16'h8000) begin errors++; $display("FAIL neg_ac got %h want 8000", ac_out); end
    checks++; if (pc_out !== 16'h0005) begin errors++; $display("FAIL neg_pc got %h want 0005", pc_out); end
  endtask

  task automatic test_alu_ops;
    prog_reset;
    mem[0] = 16'h1020; mem[1] = 16'h5021; mem[2] = 16'h6022; mem[3] = 16'h7023; mem[4] = 16'h4024;
    mem[5] = 16'hB000; mem[6] = 16'hC000; mem[7] = 16'h2025; mem[8] = 16'hE000; mem[9] = 16'h0000;
    mem['h20] = 16'h00F0; mem['h21] = 16'h0FF0; mem['h22] = 16'h0F0F; mem['h23] = 16'h00FF; mem['h24] = 16'h0001;
    mem['h25] = 16'hDEAD;
    release_reset(1);
    wait_halt(150);
    checks++; if (ac_out !== 16'h0EFF) begin errors++; $display("FAIL alu_ac got %h want 0eff", ac_out); end
    checks++; if (mem['h25] !== 16'h0EFF) begin errors++; $display("FAIL alu_store got %h want 0eff", mem['h25]); end
    checks++; if (pc_out !== 16'h000A) begin errors++; $display("FAIL alu_pc got %h want 000a", pc_out); end
    checks++; if (ir_out !== 16'h0000) begin errors++; $display("FAIL alu_ir got %h want 0000", ir_out); end
  endtask

  task automatic test_wrap;
    prog_reset;
    mem[0] = 16'hD005; mem[5] = 16'hFFFF; mem['h3FFF] = 16'hA000;
    release_reset(1);
    step(7);
    checks++; if (pc_out !== 16'h3FFF) begin errors++; $display("FAIL jumpi_pc got %h want 3fff", pc_out); end
    step(3);
    checks++; if (pc_out !== 16'h0000) begin errors++; $display("FAIL wrap_pc got %h want 0000", pc_out); end
    step(2);
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL wrap_addr got %h want 0000", mem_addr); end
    checks++; if (ir_out !== 16'hA000) begin errors++; $display("FAIL wrap_ir got %h want a000", ir_out); end
  endtask

  task automatic test_store_abort;
    prog_reset;
    mem[0] = 16'h1010; mem[1] = 16'h2012; mem['h10] = 16'h1234; mem['h12] = 16'h0BAD;
    release_reset(1);
    step(12);
    checks++; if (mem_we !== 1'b1 || mem_addr !== 16'h0012) begin errors++; $display("FAIL store_wr got we=%b addr=%h want 1/0012", mem_we, mem_addr); end
    reset = 0;
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL abort_we got %b want 0", mem_we); end
    checks++; if (pc_out !== 16'h0000) begin errors++; $display("FAIL abort_pc got %h want 0000", pc_out); end
    step(3);
    checks++; if (mem['h12] !== 16'h0BAD) begin errors++; $display("FAIL abort_mem got %h want 0bad", mem['h12]); end
  endtask

  task automatic test_run_hold;
    prog_reset;
    mem[0] = 16'hE000; mem[1] = 16'hE000;
    release_reset(0);
    step(10);
    checks++; if (pc_out !== 16'h0000 || mem_we !== 1'b0) begin errors++; $display("FAIL hold_idle got pc=%h we=%b want 0000/0", pc_out, mem_we); end
    @(negedge clk) run = 1;
    step(2);
    checks++; if (pc_out !== 16'h0000) begin errors++; $display("FAIL hold_start_pc got %h want 0000", pc_out); end
    @(negedge clk) run = 0;
    step(1);
    checks++; if (pc_out !== 16'h0001) begin errors++; $display("FAIL hold_finish_pc got %h want 0001", pc_out); end
    step(10);
    checks++; if (pc_out !== 16'h0001) begin errors++; $display("FAIL hold_boundary_pc got %h want 0001", pc_out); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_program;
    test_skipcond;
    test_negative;
    test_alu_ops;
    test_wrap;
    test_store_abort;
    test_run_hold;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
